sigbuff_ctrl: RTL and testbench

SIGBUFF_CTRL -- requirements
Module: sigbuff_ctrl

---
 rtl/sigbuff_ctrl.sv | 141 ++++++++++++++
 tb/tb_sigbuff_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigbuff_ctrl.sv
// Signal buffer: captures a burst of filter samples into a local array and replays them.
// Optional abort input is compiled in when SIGBUFF_CTRL_ABORT_EN is defined.
module sigbuff_ctrl #(
  parameter int BUFF_DEPTH = 1024,
  parameter int CNT_W      = $clog2(BUFF_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wr_start,
  input  logic             rd_start,
  input  logic [CNT_W-1:0] iter_len,
  output logic [15:0]      sigbuff_data,
  output logic             sigbuff_valid,
  input  logic             sigbuff_ready,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
`ifdef SIGBUFF_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int AW = $clog2(BUFF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;     // write address in WRITE, next read address in READ
  logic [CNT_W-1:0] hs_cnt_q;  // completed output handshakes in READ
  logic             valid_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      rd_data_q;
  logic [15:0]      mem [BUFF_DEPTH];

  logic [CNT_W-1:0] len_d;
  logic             abort_w;
  logic             start_any;
  logic             wr_fire;
  logic             wr_last;
  logic             rd_load;
  logic             rd_hs;
  logic             rd_last;

`ifdef SIGBUFF_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign len_d     = (iter_len > CNT_W'(BUFF_DEPTH)) ? CNT_W'(BUFF_DEPTH) : iter_len;
  assign start_any = wr_start | rd_start;

  assign wr_fire = (state_q == S_WRITE) & in_valid;
  assign wr_last = wr_fire & (cnt_q == len_q - CNT_W'(1));

  // The output register is refilled whenever it is empty or being drained, giving
  // one sample per cycle with no bubbles while sigbuff_ready stays high.
  assign rd_load = (state_q == S_READ) & (cnt_q != len_q) & (~valid_q | sigbuff_ready);
  assign rd_hs   = valid_q & sigbuff_ready;
  assign rd_last = (state_q == S_READ) & rd_hs & (hs_cnt_q == len_q - CNT_W'(1));

  assign in_ready      = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE);
  assign sigbuff_valid = valid_q;
  assign sigbuff_data  = valid_q ? rd_data_q : 16'h0000;
  assign cmd_err       = err_q;
  // Replay completion is flagged alongside the final handshake itself.
  assign done          = done_q | (rd_last & ~abort_w);

  // NOTE: the storage array carries no reset so it maps onto block RAM; a reset
  // only restarts control, and stale contents are never exposed unqualified.
  always_ff @(posedge clock) begin
    if (wr_fire && !reset) mem[cnt_q[AW-1:0]] <= in_data;
    if (rd_load)           rd_data_q <= mem[cnt_q[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      hs_cnt_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && start_any) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_any) begin
            if (wr_start && rd_start) err_q <= 1'b1;
            len_q    <= len_d;
            cnt_q    <= '0;
            hs_cnt_q <= '0;
            if (len_d == '0) done_q  <= 1'b1;
            else             state_q <= wr_start ? S_WRITE : S_READ;
          end
        end

        S_WRITE: begin
          if (abort_w) begin
            state_q <= S_IDLE;
          end else if (wr_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (wr_last) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (abort_w) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end else begin
            if (rd_load) begin
              valid_q <= 1'b1;
              cnt_q   <= cnt_q + CNT_W'(1);
            end else if (rd_hs) begin
              valid_q <= 1'b0;
            end
            if (rd_hs)   hs_cnt_q <= hs_cnt_q + CNT_W'(1);
            if (rd_last) state_q  <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigbuff_ctrl.sv
// Directed bench for sigbuff_ctrl: a cycle-vector table for capture/replay/stall/error
// flows, plus hand-written sequences for reset, depth clamping and abort.
module tb_sigbuff_ctrl;

  localparam int DEPTH = 1024;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_start;
  logic          rd_start;
  logic [CW-1:0] iter_len;
  logic [15:0]   sigbuff_data;
  logic          sigbuff_valid;
  logic          sigbuff_ready;
  logic          busy;
  logic          done;
  logic          cmd_err;
`ifdef SIGBUFF_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sigbuff_ctrl #(.BUFF_DEPTH(DEPTH)) dut (
    .clock         (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wr_start      (wr_start),
    .rd_start      (rd_start),
    .iter_len      (iter_len),
    .sigbuff_data  (sigbuff_data),
    .sigbuff_valid (sigbuff_valid),
    .sigbuff_ready (sigbuff_ready),
    .busy          (busy),
    .done          (done),
    .cmd_err       (cmd_err)
`ifdef SIGBUFF_CTRL_ABORT_EN
    ,
    .abort         (abort)
`endif
  );

  typedef struct {
    logic        ws;
    logic        rs;
    int          len;
    logic        iv;
    logic [15:0] id;
    logic        rdy;
    logic        e_ir;
    logic        e_sv;
    logic [15:0] e_sd;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic ws, input logic rs, input int len, input logic iv,
                   input int id, input logic rdy, input logic e_ir, input logic e_sv,
                   input int e_sd, input logic e_busy, input logic e_done, input logic e_err);
    vec_t t;
    t.ws = ws; t.rs = rs; t.len = len; t.iv = iv; t.id = 16'(id); t.rdy = rdy;
    t.e_ir = e_ir; t.e_sv = e_sv; t.e_sd = 16'(e_sd);
    t.e_busy = e_busy; t.e_done = e_done; t.e_err = e_err;
    tbl.push_back(t);
  endtask

  task automatic check_all(input string tag, input logic e_ir, input logic e_sv,
                           input int e_sd, input logic e_busy, input logic e_done,
                           input logic e_err);
    check({tag, ".in_ready"},      in_ready,      e_ir);
    check({tag, ".sigbuff_valid"}, sigbuff_valid, e_sv);
    check({tag, ".sigbuff_data"},  sigbuff_data,  32'(e_sd) & 32'hffff);
    check({tag, ".busy"},          busy,          e_busy);
    check({tag, ".done"},          done,          e_done);
    check({tag, ".cmd_err"},       cmd_err,       e_err);
  endtask

  task automatic idle_inputs();
    wr_start = 1'b0; rd_start = 1'b0; iter_len = '0;
    in_valid = 1'b0; in_data = '0; sigbuff_ready = 1'b0;
  endtask

  initial begin
    int  acc;
    bit  seen_done;

    // Capture 1..8
    v(1,0,8, 0,0, 0,  0,0,0, 0,0,0);
    for (int k = 1; k <= 8; k++) v(0,0,0, 1,k, 0,  1,0,0, 1,0,0);
    v(0,0,0, 0,0, 0,  0,0,0, 0,1,0);
    v(0,0,0, 0,0, 0,  0,0,0, 0,0,0);
    // Replay with ready held high
    v(0,1,8, 0,0, 1,  0,0,0, 0,0,0);
    v(0,0,0, 0,0, 1,  0,0,0, 1,0,0);
    for (int k = 1; k <= 8; k++) v(0,0,0, 0,0, 1,  0,1,k, 1,(k == 8),0);
    v(0,0,0, 0,0, 1,  0,0,0, 0,0,0);
    // Replay with ready toggling 1,0,1,0 from the first valid cycle
    v(0,1,8, 0,0, 0,  0,0,0, 0,0,0);
    v(0,0,0, 0,0, 0,  0,0,0, 1,0,0);
    v(0,0,0, 0,0, 1,  0,1,1, 1,0,0);
    for (int n = 2; n <= 8; n++) begin
      v(0,0,0, 0,0, 0,  0,1,n, 1,0,0);
      v(0,0,0, 0,0, 1,  0,1,n, 1,(n == 8),0);
    end
    v(0,0,0, 0,0, 0,  0,0,0, 0,0,0);
    // Zero-length capture: immediate done, no in_ready
    v(1,0,0, 1,16'hdead, 0,  0,0,0, 0,0,0);
    v(0,0,0, 1,16'hdead, 0,  0,0,0, 0,1,0);
    v(0,0,0, 0,0, 0,  0,0,0, 0,0,0);
    // Simultaneous starts: write wins, error becomes sticky
    v(1,1,4, 0,0, 0,  0,0,0, 0,0,0);
    for (int k = 0; k < 4; k++) v(0,0,0, 1,16'ha0 + k, 0,  1,0,0, 1,0,1);
    v(0,0,0, 0,0, 0,  0,0,0, 0,1,1);
    v(0,0,0, 0,0, 0,  0,0,0, 0,0,1);
    // Replay returns the most recent capture
    v(0,1,4, 0,0, 1,  0,0,0, 0,0,1);
    v(0,0,0, 0,0, 1,  0,0,0, 1,0,1);
    for (int k = 0; k < 4; k++) v(0,0,0, 0,0, 1,  0,1,16'ha0 + k, 1,(k == 3),1);
    v(0,0,0, 0,0, 1,  0,0,0, 0,0,1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all("reset", 0,0,0, 0,0,0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      wr_start = tbl[i].ws; rd_start = tbl[i].rs; iter_len = CW'(tbl[i].len);
      in_valid = tbl[i].iv; in_data = tbl[i].id; sigbuff_ready = tbl[i].rdy;
      #1 check_all($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_sv, tbl[i].e_sd,
                   tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
    end

    // Start pulse coincident with reset is ignored
    @(negedge clk);
    idle_inputs();
    reset = 1'b1; wr_start = 1'b1; iter_len = CW'(8);
    @(negedge clk);
    reset = 1'b0; wr_start = 1'b0; iter_len = '0;
    #1 check_all("rst_start0", 0,0,0, 0,0,0);
    @(negedge clk);
    #1 check_all("rst_start1", 0,0,0, 0,0,0);

    // Oversized length clamps to DEPTH; rd_start mid-capture is rejected
    @(negedge clk);
    wr_start = 1'b1; iter_len = CW'(DEPTH + 5); in_valid = 1'b1; in_data = '0;
    acc = 0; seen_done = 0;
    @(negedge clk);
    wr_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      in_data  = 16'(acc);
      rd_start = (cyc == 10);
      #1;
      if (done) seen_done = 1;
      else if (in_ready) acc++;
      @(negedge clk);
    end
    rd_start = 1'b0; in_valid = 1'b0;
    check("clamp.done_seen", 32'(seen_done), 1);
    check("clamp.count", acc, DEPTH);
    #1 check("clamp.busy", busy, 0);
    check("clamp.cmd_err", cmd_err, 1);

    // Replay of the clamped capture, reset after three handshakes
    @(negedge clk);
    rd_start = 1'b1; iter_len = CW'(8); sigbuff_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    #1 check_all("rrst.c1", 0,0,0, 1,0,1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check_all($sformatf("rrst.d%0d", k), 0,1,k, 1,0,1);
    end
    @(negedge clk);
    sigbuff_ready = 1'b0; reset = 1'b1;
    #1 check_all("rrst.d3", 0,1,3, 1,0,1);
    @(negedge clk);
    reset = 1'b0;
    #1 check_all("rrst.after", 0,0,0, 0,0,0);
    @(negedge clk);
    #1 check_all("rrst.after2", 0,0,0, 0,0,0);

`ifdef SIGBUFF_CTRL_ABORT_EN
    // Abort after four of eight writes
    @(negedge clk);
    wr_start = 1'b1; iter_len = CW'(8);
    @(negedge clk);
    wr_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 16'(k + 16'h50);
      #1 check_all($sformatf("abort.w%0d", k), 1,0,0, 1,0,0);
      @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b1;
    #1 check_all("abort.cyc", 1,0,0, 1,0,0);
    @(negedge clk);
    abort = 1'b0;
    #1 check_all("abort.next", 0,0,0, 0,0,0);
    @(negedge clk);
    #1 check_all("abort.next2", 0,0,0, 0,0,0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
